// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared types and constants for the display arbiter: FSM state
//            encoding, digit count, default value width and the round-robin
//            winner helper.
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

  // Number of packed BCD digits driven to the seven-segment controller
  localparam int NUM_DIGITS = 4;

  // Default binary width of each requester value (8191 max -> four digits)
  localparam int DEFAULT_VAL_W = 13;

  // Arbiter FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  // Round-robin pick: a lone requester always wins; on a tie the requester
  // that was not granted last wins. Returns the winning index (0 or 1).
  function automatic logic pick_winner(input logic [1:0] req, input logic last);
    logic win;
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~last;
      default: win = 1'b0;
    endcase
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter_if
// Purpose  : Request / value / display bundle between the two requesters
//            (master side) and the display arbiter (slave side).
// Revision : 1.0 - initial release
// ============================================================================
interface display_arbiter_if #(
  parameter int VAL_W = display_pkg::DEFAULT_VAL_W
);

  logic [1:0]                          req;
  logic [VAL_W-1:0]                    value0;
  logic [VAL_W-1:0]                    value1;
  logic [1:0]                          grant;
  logic [4*display_pkg::NUM_DIGITS-1:0] digits;
  logic                                bcd_valid;
  logic                                busy;

  // Requester side: raises requests and offers values
  modport master (
    output req, value0, value1,
    input  grant, digits, bcd_valid, busy
  );

  // Arbiter side
  modport slave (
    input  req, value0, value1,
    output grant, digits, bcd_valid, busy
  );

endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Iterative shift-add-3 (double-dabble) binary to BCD converter.
//            A start pulse loads the operand; each following cycle adjusts
//            every nibble >= 5 by +3 and shifts in one operand bit, MSB first.
//            done is high during the cycle whose edge performs the final
//            shift, and bcd then shows the finished result.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int VAL_W      = DEFAULT_VAL_W,
  parameter int NUM_DIG    = NUM_DIGITS
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   start,
  input  wire logic [VAL_W-1:0]       bin,
  output logic                        done,
  output logic [4*NUM_DIG-1:0]        bcd
);

  localparam int BCD_W = 4 * NUM_DIG;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VAL_W - 1);

  logic                active_q, active_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [VAL_W-1:0]    bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]    bcd_q,    bcd_d;
  logic [BCD_W-1:0]    adjusted;
  logic [BCD_W-1:0]    bcd_next;

  // One double-dabble step: add 3 to each nibble >= 5, then shift in the next MSB
  always_comb begin
    adjusted = bcd_q;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (adjusted[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = adjusted[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = {adjusted[BCD_W-2:0], bin_sr_q[VAL_W-1]};
  end

  assign done = active_q && (cnt_q == LAST_SHIFT);
  assign bcd  = bcd_next;

  // Next-state for the shift registers and shift counter
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bin_sr_d = bin_sr_q;
    bcd_d    = bcd_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bin_sr_d = bin;
      bcd_d    = '0;
    end else if (active_q) begin
      bcd_d    = bcd_next;
      bin_sr_d = {bin_sr_q[VAL_W-2:0], 1'b0};
      cnt_d    = cnt_q + CNT_W'(1);
      if (done) begin
        active_d = 1'b0;
      end
    end
  end

  // Converter state registers; reset abandons any conversion in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bin_sr_q <= '0;
      bcd_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bin_sr_q <= bin_sr_d;
      bcd_q    <= bcd_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter
// Purpose  : Round-robin arbiter between two requesters sharing a four-digit
//            seven-segment display. The winner's binary value is captured,
//            converted to packed BCD by bin2bcd_seq, loaded onto digits and
//            held for at least HOLD_CYCLES cycles before the next grant.
// Revision : 1.0 - initial release
// ============================================================================
module display_arbiter
  import display_pkg::*;
#(
  parameter logic [25:0] HOLD_CYCLES = 26'd50_000_000,
  parameter int          VAL_W       = DEFAULT_VAL_W
) (
  input  wire logic          clk,
  input  wire logic          reset,
  display_arbiter_if.slave   bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;

  state_t             state_q,     state_d;
  logic [1:0]         grant_q,     grant_d;
  logic [BCD_W-1:0]   digits_q,    digits_d;
  logic               bcd_valid_q, bcd_valid_d;
  logic [25:0]        hold_cnt_q,  hold_cnt_d;
  logic               last_q,      last_d;
  logic [VAL_W-1:0]   value_q,     value_d;
  logic               start_q,     start_d;

  logic               winner;
  logic [26:0]        hold_next;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  assign winner    = pick_winner(bus.req, last_q);
  assign hold_next = {1'b0, hold_cnt_q} + 27'd1;

  // Converter starts the cycle after capture, working on the latched value so
  // that later changes on value0/value1 cannot disturb the result.
  bin2bcd_seq #(
    .VAL_W   (VAL_W),
    .NUM_DIG (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (start_q),
    .bin   (value_q),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Arbiter FSM next-state: capture in IDLE, wait for the converter, then hold
  always_comb begin
    state_d     = state_q;
    grant_d     = 2'b00;
    digits_d    = digits_q;
    bcd_valid_d = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    value_d     = value_q;
    start_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          grant_d = winner ? 2'b10 : 2'b01;
          value_d = winner ? bus.value1 : bus.value0;
          last_d  = winner;
          start_d = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) begin
          digits_d    = conv_bcd;
          bcd_valid_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // HOLD_CYCLES of 0 or 1 both leave on the first HOLD edge
        if (hold_next >= {1'b0, HOLD_CYCLES}) begin
          hold_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          hold_cnt_d = hold_next[25:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered FSM state and outputs; pointer resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      digits_q    <= '0;
      bcd_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
      last_q      <= 1'b1;
      value_q     <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      digits_q    <= digits_d;
      bcd_valid_q <= bcd_valid_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
      value_q     <= value_d;
      start_q     <= start_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.digits    = digits_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
